// File: rtl/overlay_animator_pkg.sv
// Shared types and constants for the animated VGA overlay: palette, fade states,
// mode encodings and the quarter-wave sine table used by the trail layers.
package overlay_pkg;

  typedef enum logic [1:0] {SHOW, FADE_OUT, HIDDEN, FADE_IN} fade_state_t;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_SINE = 2'b01,
    MODE_TEXT = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  localparam logic [5:0] SHADOW_RGB  = 6'b01_01_01;
  localparam logic [9:0] SINE_CENTRE = 10'd240;

  function automatic logic [5:0] palette_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 6'b111111;
      3'd1:    return 6'b110000;
      3'd2:    return 6'b111000;
      3'd3:    return 6'b111100;
      3'd4:    return 6'b001100;
      3'd5:    return 6'b001011;
      3'd6:    return 6'b000011;
      default: return 6'b100011;
    endcase
  endfunction

  // round(32*sin(q*pi/32)) for q = 0..16; one quarter of a 64-step period
  function automatic logic [5:0] sine_quarter(input logic [4:0] q);
    case (q)
      5'd0:    return 6'd0;
      5'd1:    return 6'd3;
      5'd2:    return 6'd6;
      5'd3:    return 6'd9;
      5'd4:    return 6'd12;
      5'd5:    return 6'd15;
      5'd6:    return 6'd18;
      5'd7:    return 6'd20;
      5'd8:    return 6'd23;
      5'd9:    return 6'd25;
      5'd10:   return 6'd27;
      5'd11:   return 6'd28;
      5'd12:   return 6'd30;
      5'd13:   return 6'd31;
      5'd14:   return 6'd31;
      5'd15:   return 6'd32;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/overlay_animator_if.sv
// Pixel-stream bundle between the VGA timing/mux logic and the overlay animator.
interface overlay_animator_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_active;
  logic       frame_start;
  logic       enable_anim;
  logic [1:0] mode;
  logic [5:0] overlay_rgb;
  logic       overlay_active;

  modport master (
    output x, y, frame_active, frame_start, enable_anim, mode,
    input  overlay_rgb, overlay_active
  );

  modport slave (
    input  x, y, frame_active, frame_start, enable_anim, mode,
    output overlay_rgb, overlay_active
  );
endinterface

// File: rtl/overlay_animator_fade_fsm.sv
// Per-frame text fade sequencer: SHOW(3) -> FADE_OUT(2,1) -> HIDDEN(0) -> FADE_IN(1,2) -> SHOW.
module overlay_fade_fsm
  import overlay_pkg::*;
#(
  parameter int HOLD_FRAMES = 120,
  parameter int FADE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       enable_anim,
  output logic [1:0] level
);
  localparam int MAX_FRAMES = (HOLD_FRAMES > FADE_FRAMES) ? HOLD_FRAMES : FADE_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0] FADE_LAST = CW'(FADE_FRAMES - 1);

  fade_state_t   state;
  logic [CW-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SHOW;
      level     <= 2'd3;
      frame_cnt <= '0;
    end else if (frame_start && enable_anim) begin
      unique case (state)
        SHOW:
          if (frame_cnt == HOLD_LAST) begin
            state     <= FADE_OUT;
            level     <= 2'd2;
            frame_cnt <= '0;
          end else frame_cnt <= frame_cnt + CW'(1);
        FADE_OUT:
          if (frame_cnt == FADE_LAST) begin
            level     <= level - 2'd1;
            frame_cnt <= '0;
            if (level == 2'd1) state <= HIDDEN;
          end else frame_cnt <= frame_cnt + CW'(1);
        HIDDEN:
          if (frame_cnt == HOLD_LAST) begin
            state     <= FADE_IN;
            level     <= 2'd1;
            frame_cnt <= '0;
          end else frame_cnt <= frame_cnt + CW'(1);
        FADE_IN:
          if (frame_cnt == FADE_LAST) begin
            level     <= level + 2'd1;
            frame_cnt <= '0;
            if (level == 2'd2) state <= SHOW;
          end else frame_cnt <= frame_cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: rtl/overlay_animator_masks.sv
// Pixel masks: 3-pixel-thick sine trail (256 px period) and the three text sprites.
module sine_layer
  import overlay_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);
  logic [1:0] quad;
  logic [3:0] q;
  logic [5:0] mag;
  logic [9:0] yc;
  logic       unused_bits;

  assign unused_bits = ^{x[9:8], x[1:0]};

  always_comb begin
    quad = x[7:6];
    q    = x[5:2];
    mag  = quad[0] ? sine_quarter(5'd16 - {1'b0, q}) : sine_quarter({1'b0, q});
    yc   = quad[1] ? SINE_CENTRE - {4'b0, mag} : SINE_CENTRE + {4'b0, mag};
    hit  = (y + 10'd1 == yc) || (y == yc) || (y == yc + 10'd1);
  end
endmodule

module text_demosiine (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);
  always_comb
    hit = (x >= 10'd96) && (x <= 10'd223) && (y >= 10'd48) && (y <= 10'd63) && (x[2] == y[2]);
endmodule

module text_tt08 (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);
  always_comb
    hit = (x >= 10'd288) && (x <= 10'd351) && (y >= 10'd48) && (y <= 10'd63) && !x[3];
endmodule

module text_sda (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);
  always_comb
    hit = (x >= 10'd400) && (x <= 10'd463) && (y >= 10'd208) && (y <= 10'd223) && !x[2];
endmodule

// File: rtl/overlay_animator.sv
// Animated overlay: scrolling rainbow sine trails over fading, shadowed text sprites.
// Output is registered one pixel clock after x/y.
module overlay_animator
  import overlay_pkg::*;
#(
  parameter int N_TRAIL       = 8,
  parameter int TRAIL_SPACING = 1,
  parameter int PHASE_STEP    = 2,
  parameter int SHADOW_DX     = 4,
  parameter int SHADOW_DY     = 4,
  parameter int HOLD_FRAMES   = 120,
  parameter int FADE_FRAMES   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  overlay_animator_if.slave   bus
);
  logic [9:0]         phase;
  logic [1:0]         level;
  logic [N_TRAIL-1:0] trail_hit;
  logic [2:0]         main_hit;
  logic [2:0]         shadow_hit;
  logic [9:0]         shadow_x;
  logic [9:0]         shadow_y;
  logic               trail_any;
  logic [5:0]         trail_rgb;
  logic               sine_en;
  logic               text_en;
  logic [5:0]         rgb_next;
  logic               active_next;

  always_ff @(posedge clk) begin
    if (!rst_n) phase <= '0;
    else if (bus.frame_start && bus.enable_anim) phase <= phase + 10'(PHASE_STEP);
  end

  overlay_fade_fsm #(
    .HOLD_FRAMES(HOLD_FRAMES),
    .FADE_FRAMES(FADE_FRAMES)
  ) u_fade (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (bus.frame_start),
    .enable_anim (bus.enable_anim),
    .level       (level)
  );

  for (genvar k = 0; k < N_TRAIL; k++) begin : g_trail
    logic [9:0] xs;
    assign xs = bus.x - phase - 10'(k * TRAIL_SPACING);
    sine_layer u_sine (.x(xs), .y(bus.y), .hit(trail_hit[k]));
  end

  assign shadow_x = bus.x - 10'(SHADOW_DX);
  assign shadow_y = bus.y - 10'(SHADOW_DY);

  text_demosiine u_demo_main (.x(bus.x),    .y(bus.y),    .hit(main_hit[0]));
  text_tt08      u_tt08_main (.x(bus.x),    .y(bus.y),    .hit(main_hit[1]));
  text_sda       u_sda_main  (.x(bus.x),    .y(bus.y),    .hit(main_hit[2]));
  text_demosiine u_demo_shad (.x(shadow_x), .y(shadow_y), .hit(shadow_hit[0]));
  text_tt08      u_tt08_shad (.x(shadow_x), .y(shadow_y), .hit(shadow_hit[1]));
  text_sda       u_sda_shad  (.x(shadow_x), .y(shadow_y), .hit(shadow_hit[2]));

  always_comb begin
    trail_any = 1'b0;
    trail_rgb = '0;
    for (int unsigned i = 0; i < N_TRAIL; i++) begin
      if (trail_hit[i] && !trail_any) begin
        trail_any = 1'b1;
        trail_rgb = palette_rgb(3'(i));
      end
    end
  end

  // All text sprites share one colour, so their internal priority reduces to an OR
  always_comb begin
    sine_en     = (bus.mode == MODE_ALL) || (bus.mode == MODE_SINE);
    text_en     = (bus.mode == MODE_ALL) || (bus.mode == MODE_TEXT);
    rgb_next    = '0;
    active_next = 1'b0;
    if (bus.frame_active) begin
      if (sine_en && trail_any) begin
        rgb_next    = trail_rgb;
        active_next = 1'b1;
      end else if (text_en && (|main_hit) && (level != 2'd0)) begin
        rgb_next    = {level, level, level};
        active_next = 1'b1;
      end else if (text_en && (|shadow_hit) && (level == 2'd3)) begin
        rgb_next    = SHADOW_RGB;
        active_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.overlay_rgb    <= '0;
      bus.overlay_active <= 1'b0;
    end else begin
      bus.overlay_rgb    <= rgb_next;
      bus.overlay_active <= active_next;
    end
  end
endmodule

// File: tb/tb_overlay_animator.sv
// Self-checking bench for overlay_animator: directed literal checks plus a
// randomized run compared every cycle against a frame-count based reference model.
module tb_overlay_animator;
  localparam int NT  = 8;
  localparam int SP  = 1;
  localparam int PS  = 2;
  localparam int SDX = 4;
  localparam int SDY = 4;
  localparam int H   = 4;
  localparam int F   = 2;
  localparam logic [5:0] PAL [8] = '{6'b111111, 6'b110000, 6'b111000, 6'b111100,
                                    6'b001100, 6'b001011, 6'b000011, 6'b100011};

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_miss = 0;
  int   anim = 0;
  int   exp_v = 0;

  overlay_animator_if bus();

  overlay_animator #(
    .N_TRAIL(NT), .TRAIL_SPACING(SP), .PHASE_STEP(PS),
    .SHADOW_DX(SDX), .SHADOW_DY(SDY), .HOLD_FRAMES(H), .FADE_FRAMES(F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Level as a function of animated frames since reset: 3 for H, 2,1 for F each, 0 for H, 1,2 for F each
  function automatic int level_of(input int n);
    int t;
    t = n % (2 * H + 4 * F);
    if (t < H)             return 3;
    if (t < H + F)         return 2;
    if (t < H + 2 * F)     return 1;
    if (t < 2 * H + 2 * F) return 0;
    if (t < 2 * H + 3 * F) return 1;
    return 2;
  endfunction

  function automatic int sine_y(input int xp);
    int  i;
    real s;
    i = (xp / 4) % 64;
    s = 32.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 64.0);
    return 240 + int'($floor(s + 0.5));
  endfunction

  function automatic bit text_on(input int x, input int y);
    if (x >= 96 && x <= 223 && y >= 48 && y <= 63 && (((x - 96) / 4 + (y - 48) / 4) % 2 == 0)) return 1;
    if (x >= 288 && x <= 351 && y >= 48 && y <= 63 && ((x - 288) / 8) % 2 == 0) return 1;
    if (x >= 400 && x <= 463 && y >= 208 && y <= 223 && ((x - 400) / 4) % 2 == 0) return 1;
    return 0;
  endfunction

  // Returns active*64 + rgb
  function automatic int expect_px(input int x, input int y, input bit fa, input int mode,
                                   input int phase, input int lvl);
    int xp, yc;
    if (!fa || mode == 3) return 0;
    if (mode != 2)
      for (int k = 0; k < NT; k++) begin
        xp = (x - phase - k * SP + 4096) % 1024;
        yc = sine_y(xp);
        if (y >= yc - 1 && y <= yc + 1) return 64 + int'(PAL[k % 8]);
      end
    if (mode != 1 && lvl != 0 && text_on(x, y)) return 64 + lvl * 21;
    if (mode != 1 && lvl == 3 && text_on((x - SDX + 1024) % 1024, (y - SDY + 1024) % 1024)) return 64 + 21;
    return 0;
  endfunction

  task automatic check(input string name, input logic [6:0] want);
    n_vec++;
    if ({bus.overlay_active, bus.overlay_rgb} !== want) begin
      n_miss++;
      $display("FAIL %s @%0t: got act=%b rgb=%b, want act=%b rgb=%b", name, $time,
               bus.overlay_active, bus.overlay_rgb, want[6], want[5:0]);
    end
  endtask

  task automatic lit(input string name, input int x, input int y, input bit fa, input int mode,
                     input logic [6:0] want);
    @(negedge clk);
    bus.x = 10'(x);
    bus.y = 10'(y);
    bus.frame_active = fa;
    bus.mode = 2'(mode);
    bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    check(name, want);
  endtask

  task automatic pulse(input int n, input bit en);
    repeat (n) begin
      @(negedge clk);
      bus.frame_start  = 1'b1;
      bus.enable_anim  = en;
      bus.frame_active = 1'b0;
      @(negedge clk);
      bus.frame_start  = 1'b0;
    end
  endtask

  // Reference model: sample inputs at the edge, state from frames counted so far
  always @(posedge clk) begin
    if (!rst_n) begin
      anim  = 0;
      exp_v = 0;
    end else begin
      exp_v = expect_px(int'(bus.x), int'(bus.y), bus.frame_active, int'(bus.mode),
                        (anim * PS) % 1024, level_of(anim));
      if (bus.frame_start && bus.enable_anim) anim++;
    end
    #1;
    check("pixel", 7'(exp_v));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] seq [17] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0,
                             2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    int fx, fy, ph, lv, v, rx, ry;
    rst_n            = 1'b0;
    bus.x            = 10'd3;
    bus.y            = 10'd240;
    bus.frame_active = 1'b1;
    bus.frame_start  = 1'b1;
    bus.enable_anim  = 1'b1;
    bus.mode         = 2'b00;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 7'b0_000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 7'b1_111111);

    lit("white_l0", 3, 240, 1, 0, 7'b1_111111);
    lit("red_l1",   4, 240, 1, 0, 7'b1_110000);
    pulse(3, 1);
    lit("scroll_white", 9, 240, 1, 0, 7'b1_111111);
    pulse(5, 0);
    lit("hold_white", 9, 240, 1, 0, 7'b1_111111);
    pulse(509, 1);
    lit("wrap_white", 3, 240, 1, 0, 7'b1_111111);
    lit("wrap_red",   4, 240, 1, 0, 7'b1_110000);

    for (int i = 0; i < 17; i++) begin
      lit("fade_main", 96, 48, 1, 0, (seq[i] == 2'd0) ? 7'b0_000000 : {1'b1, seq[i], seq[i], seq[i]});
      lit("fade_shadow", 226, 56, 1, 0, (seq[i] == 2'd3) ? 7'b1_010101 : 7'b0_000000);
      if (i < 16) pulse(1, 1);
    end

    // phase is now 32 after 528 animated frames
    lit("mode_all",   35, 240, 1, 0, 7'b1_111111);
    lit("mode_off",   35, 240, 1, 3, 7'b0_000000);
    lit("blank",      35, 240, 0, 0, 7'b0_000000);
    lit("sine_only",  96, 48,  1, 1, 7'b0_000000);
    lit("text_only",  35, 240, 1, 2, 7'b0_000000);

    fx = -1;
    fy = -1;
    ph = (anim * PS) % 1024;
    lv = level_of(anim);
    for (int xx = 400; xx <= 463 && fx < 0; xx++)
      for (int yy = 208; yy <= 223 && fx < 0; yy++) begin
        v = expect_px(xx, yy, 1, 0, ph, lv);
        if (text_on(xx, yy) && v >= 64 && v != 127) begin
          fx = xx;
          fy = yy;
        end
      end
    if (fx >= 0) begin
      lit("overlap_sine", fx, fy, 1, 0, 7'(expect_px(fx, fy, 1, 0, ph, lv)));
      lit("overlap_text", fx, fy, 1, 2, 7'b1_111111);
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL overlap_search: got no pixel, want a sine+text pixel");
    end

    repeat (3000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 3))
        0: begin rx = $urandom_range(0, 1023); ry = $urandom_range(0, 1023); end
        1: begin rx = $urandom_range(0, 1023); ry = $urandom_range(205, 275); end
        2: begin rx = $urandom_range(90, 360); ry = $urandom_range(44, 70); end
        default: begin rx = $urandom_range(396, 470); ry = $urandom_range(204, 230); end
      endcase
      bus.x            = 10'(rx);
      bus.y            = 10'(ry);
      bus.frame_active = ($urandom_range(0, 9) != 0);
      bus.frame_start  = ($urandom_range(0, 5) == 0);
      bus.enable_anim  = ($urandom_range(0, 3) != 0);
      bus.mode         = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.frame_start = 1'b0;
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
